// File: rtl/fetch_unit_pkg.sv
// Shared CPU front-end definitions: instruction width, fetch FSM encoding
// and the default reset PC.
package cpu_defs;

  localparam int INST_WIDTH = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory request/response channels,
// core redirect input and the instruction delivery channel.
interface fetch_unit_if #(
  parameter int PC_WIDTH = 32
);
  import cpu_defs::*;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [PC_WIDTH-1:0]   mem_req_addr;
  logic                  mem_rsp_valid;
  logic [INST_WIDTH-1:0] mem_rsp_data;
  logic                  redirect_valid;
  logic [PC_WIDTH-1:0]   redirect_pc;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [INST_WIDTH-1:0] inst_data;
  logic [PC_WIDTH-1:0]   inst_pc;

  modport master (
    output mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
           redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
           redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Synchronous FIFO of {pc, instruction}; flush wins over push and pop.
module fetch_fifo
  import cpu_defs::*;
#(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [PC_WIDTH-1:0]      push_pc,
  input  logic [INST_WIDTH-1:0]    push_inst,
  output logic [PC_WIDTH-1:0]      head_pc,
  output logic [INST_WIDTH-1:0]    head_inst,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [PC_WIDTH-1:0]   pc_mem   [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign head_pc   = pc_mem[rd_ptr[AW-1:0]];
  assign head_inst = inst_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr[AW-1:0]]   <= push_pc;
      inst_mem[wr_ptr[AW-1:0]] <= push_inst;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory request at a time,
// FIFO-buffered delivery to the core, redirect flush with stale-response drop.
//
//   state  | meaning
//   S_IDLE | no request outstanding; request fetch_pc when the FIFO has room
//   S_WAIT | one request accepted, waiting for its response
module fetch_unit
  import cpu_defs::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter int                  DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e        state, state_nxt;
  logic [PC_WIDTH-1:0] fetch_pc, fetch_pc_nxt;
  logic [PC_WIDTH-1:0] req_pc, req_pc_nxt;
  logic                drop, drop_nxt;
  logic                req_valid;
  logic                req_fire;
  logic                push;
  logic                pop;
  logic                fifo_empty;
  logic                fifo_full;
  logic [CW-1:0]       fifo_count;
  logic [PC_WIDTH-1:0] head_pc;
  logic [INST_WIDTH-1:0] head_inst;

  // Only one request is ever in flight, so room for one more entry suffices.
  assign req_valid = !reset && (state == S_IDLE) && (fifo_count < CW'(DEPTH));
  assign req_fire  = req_valid && bus.mem_req_ready;
  assign pop       = !fifo_empty && bus.inst_ready;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_pc_nxt   = req_pc;
    drop_nxt     = drop;
    push         = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_fire) begin
          state_nxt    = S_WAIT;
          req_pc_nxt   = fetch_pc;
          fetch_pc_nxt = fetch_pc + 1'b1;
          drop_nxt     = bus.redirect_valid;
        end
      end
      S_WAIT: begin
        if (bus.mem_rsp_valid) begin
          push      = !drop && !bus.redirect_valid && !fifo_full;
          drop_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else if (bus.redirect_valid) begin
          drop_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (bus.redirect_valid) fetch_pc_nxt = bus.redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      drop     <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_pc   <= req_pc_nxt;
      drop     <= drop_nxt;
    end
  end

  fetch_fifo #(
    .DEPTH    (DEPTH),
    .PC_WIDTH (PC_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .push_pc   (req_pc),
    .push_inst (bus.mem_rsp_data),
    .head_pc   (head_pc),
    .head_inst (head_inst),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = fetch_pc;
  assign bus.inst_valid    = !fifo_empty;
  assign bus.inst_data     = head_inst;
  assign bus.inst_pc       = head_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit against a transaction-level
// model: expected request stream, a memory with random latency, and a queue
// of instructions the core should receive.
module tb_fetch_unit;
  import cpu_defs::*;

  localparam int          PW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if #(.PC_WIDTH(PW)) bus ();

  fetch_unit #(.PC_WIDTH(PW), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] exp_pc;
  bit          outstanding;
  bit          stale;
  logic [31:0] out_addr;
  int          wait_cnt;
  int          n_pass  = 0;
  int          n_total = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
  endtask

  // One clock cycle: drive inputs, check outputs, then advance the model
  // by the effects of the coming edge. lat < 0 picks a random latency.
  task automatic step(input bit rst, input bit rq_rdy, input bit in_rdy,
                      input bit redir, input logic [31:0] rpc,
                      input int lat, input bit stray);
    bit   rsp;
    bit   exp_req;
    bit   hs;
    ent_t e;
    @(negedge clk);
    reset              = rst;
    bus.mem_req_ready  = rq_rdy;
    bus.inst_ready     = in_rdy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    rsp = 1'b0;
    if (outstanding) begin
      if (wait_cnt == 0) rsp = 1'b1;
      else wait_cnt--;
    end else begin
      rsp = stray;
    end
    bus.mem_rsp_valid = rsp;
    bus.mem_rsp_data  = (rsp && outstanding) ? mem_word(out_addr) : $urandom;
    #1;
    exp_req = !rst && !outstanding && (exp_q.size() < DEPTH);
    check("req_valid", {31'd0, bus.mem_req_valid}, {31'd0, exp_req});
    check("inst_valid", {31'd0, bus.inst_valid}, {31'd0, exp_q.size() != 0});
    if (exp_req) check("req_addr", bus.mem_req_addr, exp_pc);
    if (exp_q.size() != 0) begin
      check("inst_pc", bus.inst_pc, exp_q[0].pc);
      check("inst_data", bus.inst_data, exp_q[0].data);
    end
    if (rst) begin
      exp_q.delete();
      outstanding = 1'b0;
      stale       = 1'b0;
      exp_pc      = RPC;
    end else begin
      hs = exp_req && rq_rdy;
      if (exp_q.size() != 0 && in_rdy && !redir) void'(exp_q.pop_front());
      if (outstanding && rsp) begin
        if (!stale && !redir) begin
          e.pc   = out_addr;
          e.data = mem_word(out_addr);
          exp_q.push_back(e);
        end
        outstanding = 1'b0;
        stale       = 1'b0;
      end else if (outstanding && redir) begin
        stale = 1'b1;
      end
      if (hs) begin
        outstanding = 1'b1;
        out_addr    = exp_pc;
        stale       = redir;
        wait_cnt    = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
        exp_pc      = exp_pc + 1;
      end
      if (redir) begin
        exp_q.delete();
        exp_pc = rpc;
      end
    end
  endtask

  initial begin
    reset              = 1'b1;
    bus.mem_req_ready  = 1'b0;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_data   = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;
    outstanding = 1'b0;
    stale       = 1'b0;
    out_addr    = '0;
    wait_cnt    = 0;
    exp_pc      = RPC;
    repeat (2) @(posedge clk);
    step(1, 1, 1, 0, 0, 0, 0);

    // 1-cycle memory, core always ready
    repeat (10) step(0, 1, 1, 0, 0, 0, 0);

    // core backpressure fills the FIFO, then drains
    repeat (14) step(0, 1, 0, 0, 0, 0, 0);
    repeat (10) step(0, 1, 1, 0, 0, 0, 0);

    // redirect while waiting on a slow response
    for (int i = 0; i < 6 && !outstanding; i++) step(0, 1, 1, 0, 0, 3, 0);
    step(0, 1, 1, 1, 32'h40, 3, 0);
    repeat (10) step(0, 1, 1, 0, 0, 0, 0);

    // redirect with three entries queued and the core popping
    for (int i = 0; i < 20 && exp_q.size() < 3; i++) step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 32'h80, 0, 0);
    repeat (8) step(0, 1, 1, 0, 0, 0, 0);

    // redirect coincident with a request handshake
    for (int i = 0; i < 10 && (outstanding || exp_q.size() >= DEPTH); i++)
      step(0, 1, 1, 0, 0, 1, 0);
    step(0, 1, 1, 1, 32'h100, 1, 0);
    repeat (8) step(0, 1, 1, 0, 0, 0, 0);

    // request held off by memory, then reset mid-WAIT and a stray response
    for (int i = 0; i < 10 && (outstanding || exp_q.size() >= DEPTH); i++)
      step(0, 0, 1, 0, 0, 0, 0);
    repeat (5) step(0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 3, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 1);
    repeat (6) step(0, 1, 1, 0, 0, 0, 0);

    // wrap-around of the PC
    step(0, 1, 1, 1, 32'hFFFF_FFFE, 0, 0);
    repeat (10) step(0, 1, 1, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
           $urandom_range(0, 15) == 0,
           (($urandom % 4) == 0) ? 32'hFFFF_FFFE : $urandom,
           -1, ($urandom % 8) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
